// File: rtl/mouse_pkg.sv
// Shared definitions for the mouse command scheduler: FSM state encoding,
// PS/2 response constants, receiver payload and datapath widths.
package mouse_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned ERR_W   = 2;
  localparam int unsigned TIMER_W = 24;
  localparam int unsigned RETRY_W = 2;

  localparam logic [BYTE_W-1:0] PS2_ACK    = 8'hFA;
  localparam logic [BYTE_W-1:0] PS2_RESEND = 8'hFE;
  localparam logic [ERR_W-1:0]  ERR_NONE   = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_SENT = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_DONE      = 3'd4
  } sched_state_e;

  // Byte delivered by the PS/2 receiver together with its error status.
  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic [ERR_W-1:0]  err;
  } ps2_rx_t;

endpackage

// File: rtl/ps2_rr_arbiter.sv
// Two-way round-robin grant selection.
//   req[1:0]    : request lines (bit i = requester i)
//   last_served : id of the requester served most recently
//   grant_c     : id of the winning requester (combinational; only
//                 meaningful while at least one request is high)
module ps2_rr_arbiter (
  input  logic [1:0] req,
  input  logic       last_served,
  output logic       grant_c
);

  // On a tie the requester not served last wins; a lone request always wins.
  always_comb begin
    grant_c = 1'b0;
    if (req == 2'b11) begin
      grant_c = ~last_served;
    end else if (req == 2'b10) begin
      grant_c = 1'b1;
    end
  end

endmodule

// File: rtl/mouse_cmd_scheduler.sv
// Serialises command bytes from two requesters onto a PS/2 transmitter and
// waits for the mouse acknowledge, re-sending on timeout / resend / rx error.
//   CLK, RESET                      : clock, synchronous active-high reset
//   REQ_x, CMD_x                    : command request and byte (x = 0, 1)
//   DONE_x, FAIL_x                  : completion pulse and failure flag
//   SEND_BYTE, BYTE_TO_SEND         : strobe and byte to the transmitter
//   BYTE_SENT                       : transmitter completion pulse
//   BYTE_READY, BYTE_READ,
//   BYTE_ERROR_CODE, READ_ENABLE    : receiver data/status and consume pulse
//   BUSY                            : high whenever not idle
module mouse_cmd_scheduler
  import mouse_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 2000000,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ_0,
  input  logic              REQ_1,
  input  logic [BYTE_W-1:0] CMD_0,
  input  logic [BYTE_W-1:0] CMD_1,
  output logic              DONE_0,
  output logic              DONE_1,
  output logic              FAIL_0,
  output logic              FAIL_1,
  output logic              SEND_BYTE,
  output logic [BYTE_W-1:0] BYTE_TO_SEND,
  input  logic              BYTE_SENT,
  input  logic              BYTE_READY,
  input  logic [BYTE_W-1:0] BYTE_READ,
  input  logic [ERR_W-1:0]  BYTE_ERROR_CODE,
  output logic              READ_ENABLE,
  output logic              BUSY
);

  sched_state_e        state_q, state_d;
  logic                id_q;
  logic                last_q;
  logic [TIMER_W-1:0]  timer_q;
  logic [RETRY_W-1:0]  retry_q;
  logic                grant_c;
  ps2_rx_t             rx;

  logic any_req, timeout, retry_ok;
  logic do_retry, do_fail, consume, retry_inc;
  logic send_d, done_d, busy_d;

  assign rx       = '{data: BYTE_READ, err: BYTE_ERROR_CODE};
  assign any_req  = REQ_0 | REQ_1;
  assign timeout  = (timer_q >= TIMER_W'(ACK_TIMEOUT));
  assign retry_ok = (retry_q < RETRY_W'(MAX_RETRY));

  ps2_rr_arbiter u_arb (
    .req         ({REQ_1, REQ_0}),
    .last_served (last_q),
    .grant_c     (grant_c)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; retry requests from either wait state funnel into one path.
  always_comb begin
    state_d  = state_q;
    do_retry = 1'b0;
    do_fail  = 1'b0;
    consume  = 1'b0;
    case (state_q)
      ST_IDLE:      if (any_req) state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_SENT;
      ST_WAIT_SENT: begin
        if (BYTE_SENT)    state_d  = ST_WAIT_ACK;
        else if (timeout) do_retry = 1'b1;
      end
      ST_WAIT_ACK: begin
        if (BYTE_READY) begin
          consume = 1'b1;
          if (rx.data == PS2_ACK && rx.err == ERR_NONE) begin
            state_d = ST_DONE;
          end else if (rx.data == PS2_RESEND || rx.err != ERR_NONE) begin
            do_retry = 1'b1;
          end else begin
            state_d = ST_DONE;
            do_fail = 1'b1;
          end
        end else if (timeout) begin
          do_retry = 1'b1;
        end
      end
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
    if (do_retry) begin
      if (retry_ok) begin
        state_d = ST_SEND;
      end else begin
        state_d = ST_DONE;
        do_fail = 1'b1;
      end
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    send_d    = (state_d == ST_SEND);
    done_d    = (state_d == ST_DONE);
    busy_d    = (state_d != ST_IDLE);
    retry_inc = do_retry & retry_ok;
  end

  // Output registers and transaction datapath.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEND_BYTE    <= 1'b0;
      READ_ENABLE  <= 1'b0;
      DONE_0       <= 1'b0;
      DONE_1       <= 1'b0;
      FAIL_0       <= 1'b0;
      FAIL_1       <= 1'b0;
      BUSY         <= 1'b0;
      BYTE_TO_SEND <= '0;
      timer_q      <= '0;
      retry_q      <= '0;
      id_q         <= 1'b0;
      last_q       <= 1'b1;
    end else begin
      SEND_BYTE   <= send_d;
      READ_ENABLE <= consume;
      BUSY        <= busy_d;
      DONE_0      <= done_d & ~id_q;
      DONE_1      <= done_d &  id_q;
      FAIL_0      <= do_fail & ~id_q;
      FAIL_1      <= do_fail &  id_q;

      // Byte is captured at grant so later CMD changes are harmless.
      if (state_q == ST_IDLE && any_req) begin
        id_q         <= grant_c;
        BYTE_TO_SEND <= grant_c ? CMD_1 : CMD_0;
        retry_q      <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + RETRY_W'(1);
      end

      // Timer restarts on entry to each wait state and saturates.
      if (state_q == ST_SEND || (state_q == ST_WAIT_SENT && BYTE_SENT)) begin
        timer_q <= '0;
      end else if ((state_q == ST_WAIT_SENT || state_q == ST_WAIT_ACK) &&
                   timer_q != {TIMER_W{1'b1}}) begin
        timer_q <= timer_q + TIMER_W'(1);
      end

      if (state_q == ST_DONE) begin
        last_q <= id_q;
      end
    end
  end

endmodule

// File: tb/tb_mouse_cmd_scheduler.sv
// Randomised transaction-level bench for mouse_cmd_scheduler with a
// reference model of arbitration, retry policy and completion status.
module tb_mouse_cmd_scheduler;

  localparam int unsigned TO   = 100;
  localparam int unsigned MR   = 2;
  localparam int          NATT = MR + 1;
  localparam int          WLO  = TO - 2;
  localparam int          WHI  = TO + 4;

  typedef enum int {K_ACK, K_RESEND, K_ERR, K_OTHER, K_NOSENT, K_NOACK} kind_e;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ_0 = 1'b0, REQ_1 = 1'b0;
  logic [7:0] CMD_0 = 8'h00, CMD_1 = 8'h00;
  logic       DONE_0, DONE_1, FAIL_0, FAIL_1, SEND_BYTE, READ_ENABLE, BUSY;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT = 1'b0, BYTE_READY = 1'b0;
  logic [7:0] BYTE_READ = 8'h00;
  logic [1:0] BYTE_ERROR_CODE = 2'b00;

  mouse_cmd_scheduler #(.ACK_TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RESET(RESET), .REQ_0(REQ_0), .REQ_1(REQ_1),
    .CMD_0(CMD_0), .CMD_1(CMD_1), .DONE_0(DONE_0), .DONE_1(DONE_1),
    .FAIL_0(FAIL_0), .FAIL_1(FAIL_1), .SEND_BYTE(SEND_BYTE),
    .BYTE_TO_SEND(BYTE_TO_SEND), .BYTE_SENT(BYTE_SENT),
    .BYTE_READY(BYTE_READY), .BYTE_READ(BYTE_READ),
    .BYTE_ERROR_CODE(BYTE_ERROR_CODE), .READ_ENABLE(READ_ENABLE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Pulse counters sampled mid-cycle.
  int n_send = 0, n_read = 0, n_done0 = 0, n_done1 = 0, n_orphan = 0;
  always @(negedge CLK) begin
    if (SEND_BYTE)   n_send++;
    if (READ_ENABLE) n_read++;
    if (DONE_0)      n_done0++;
    if (DONE_1)      n_done1++;
    if ((FAIL_0 && !DONE_0) || (FAIL_1 && !DONE_1)) n_orphan++;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference model state.
  bit    model_last = 1'b1;
  kind_e plan [NATT];

  function automatic bit rr_pick(input logic r0, input logic r1);
    if (r0 && r1) return model_last ? 1'b0 : 1'b1;
    return r1 && !r0;
  endfunction

  function automatic kind_e rand_kind();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 50) return K_ACK;
    if (r < 65) return K_RESEND;
    if (r < 75) return K_ERR;
    if (r < 83) return K_OTHER;
    if (r < 91) return K_NOSENT;
    return K_NOACK;
  endfunction

  task automatic random_plan();
    for (int i = 0; i < NATT; i++) plan[i] = rand_kind();
  endtask

  // Drive the receiver with the response for one attempt kind.
  task automatic drive_response(input kind_e k);
    case (k)
      K_ACK:    begin BYTE_READ = 8'hFA; BYTE_ERROR_CODE = 2'b00; end
      K_RESEND: begin BYTE_READ = 8'hFE; BYTE_ERROR_CODE = 2'b00; end
      K_ERR:    begin BYTE_READ = 8'($urandom); BYTE_ERROR_CODE = 2'($urandom_range(1, 3)); end
      default:  begin BYTE_READ = 8'($urandom_range(0, 8'hF9)); BYTE_ERROR_CODE = 2'b00; end
    endcase
    BYTE_READY = 1'b1;
  endtask

  // Runs one transaction from an IDLE cycle with REQ/CMD already applied.
  task automatic do_txn(input int sent_dly, input bit keep_winner, input bit drop_mid);
    bit         exp_id, exp_fail, fin, got_done;
    logic [7:0] exp_cmd;
    int         exp_att, exp_reads, n, m, s0, r0, d0, d1;
    kind_e      k;

    exp_id  = rr_pick(REQ_0, REQ_1);
    exp_cmd = exp_id ? CMD_1 : CMD_0;
    exp_fail = 1'b1; exp_att = NATT; exp_reads = 0;
    for (int i = 0; i < NATT; i++) begin
      if (plan[i] inside {K_ACK, K_RESEND, K_ERR, K_OTHER}) exp_reads++;
      if (plan[i] == K_ACK)   begin exp_fail = 1'b0; exp_att = i + 1; break; end
      if (plan[i] == K_OTHER) begin exp_fail = 1'b1; exp_att = i + 1; break; end
    end
    s0 = n_send; r0 = n_read; d0 = n_done0; d1 = n_done1;

    tick();
    check("send_latency", SEND_BYTE, 1);
    check("busy_in_txn", BUSY, 1);
    if (exp_id) CMD_1 = 8'($urandom); else CMD_0 = 8'($urandom);
    if (drop_mid) begin if (exp_id) REQ_1 = 1'b0; else REQ_0 = 1'b0; end

    fin = 1'b0; got_done = 1'b0;
    for (int a = 0; a <= NATT && !fin; a++) begin
      check("byte_to_send", BYTE_TO_SEND, exp_cmd);
      if (a == NATT) begin
        check("attempt_count", a, NATT - 1);
        break;
      end
      k = plan[a];
      n = 0;
      if (k == K_NOSENT) begin
        tick(); n = 1;
      end else begin
        repeat (sent_dly > 0 ? sent_dly : int'($urandom_range(1, 12))) tick();
        BYTE_SENT = 1'b1; tick(); BYTE_SENT = 1'b0;
        if (k == K_NOACK) begin
          tick(); n = 1;
        end else begin
          repeat ($urandom_range(0, 8)) tick();
          drive_response(k);
          m = 0;
          while (!READ_ENABLE && m < 6) begin tick(); m++; end
          check("read_enable_seen", READ_ENABLE, 1);
          BYTE_READY = 1'b0;
        end
      end
      while (!(SEND_BYTE || DONE_0 || DONE_1) && n < int'(TO) + 20) begin tick(); n++; end
      if (k == K_NOSENT || k == K_NOACK)
        check("timeout_gap_in_window", 32'(n >= WLO && n <= WHI), 1);
      if (!(SEND_BYTE || DONE_0 || DONE_1)) begin
        check("progress_timeout", 0, 1);
        fin = 1'b1;
      end else if (DONE_0 || DONE_1) begin
        fin = 1'b1; got_done = 1'b1;
      end
    end

    if (got_done) begin
      check("done_winner", exp_id ? DONE_1 : DONE_0, 1);
      check("done_other",  exp_id ? DONE_0 : DONE_1, 0);
      check("fail_winner", exp_id ? FAIL_1 : FAIL_0, 32'(exp_fail));
      check("fail_other",  exp_id ? FAIL_0 : FAIL_1, 0);
      model_last = exp_id;
    end
    if (!keep_winner) begin
      if (exp_id) REQ_1 = 1'b0; else REQ_0 = 1'b0;
    end else begin
      if (exp_id) CMD_1 = 8'($urandom); else CMD_0 = 8'($urandom);
    end
    tick();
    check("busy_after_done", BUSY, 0);
    check("send_count",  n_send - s0, exp_att);
    check("read_count",  n_read - r0, exp_reads);
    check("done0_count", n_done0 - d0, exp_id ? 0 : 1);
    check("done1_count", n_done1 - d1, exp_id ? 1 : 0);
  endtask

  // Receiver data while idle must not be consumed.
  task automatic idle_rx_noise();
    int r0;
    r0 = n_read;
    BYTE_READY = 1'b1; BYTE_READ = 8'($urandom);
    repeat (3) tick();
    BYTE_READY = 1'b0;
    tick();
    check("no_read_in_idle", n_read - r0, 0);
  endtask

  initial begin
    int d0, d1;
    bit r0, r1, drop;
    repeat (2) tick();
    check("rst_send_byte", SEND_BYTE, 0);
    check("rst_read_en", READ_ENABLE, 0);
    check("rst_done", {DONE_1, DONE_0}, 0);
    check("rst_fail", {FAIL_1, FAIL_0}, 0);
    check("rst_busy", BUSY, 0);
    check("rst_byte", BYTE_TO_SEND, 8'h00);
    RESET = 1'b0;
    tick();

    // Tie right after reset: 0 then 1, then 0 again on the next tie.
    REQ_0 = 1'b1; CMD_0 = 8'hE6; REQ_1 = 1'b1; CMD_1 = 8'hE8;
    plan = '{K_ACK, K_ACK, K_ACK};
    do_txn(0, 1'b0, 1'b0);
    check("tie_second_is_1", REQ_1, 1);
    do_txn(0, 1'b0, 1'b0);
    REQ_0 = 1'b1; CMD_0 = 8'h11; REQ_1 = 1'b1; CMD_1 = 8'h22;
    do_txn(0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 1'b0);

    // Enable-reporting command with a 10-cycle transmitter delay.
    REQ_0 = 1'b1; CMD_0 = 8'hF4;
    plan = '{K_ACK, K_ACK, K_ACK};
    do_txn(10, 1'b0, 1'b0);

    // Three resend responses exhaust the retries.
    REQ_1 = 1'b1; CMD_1 = 8'hF3;
    plan = '{K_RESEND, K_RESEND, K_RESEND};
    do_txn(0, 1'b0, 1'b0);

    // No acknowledge at all, and no BYTE_SENT at all.
    REQ_0 = 1'b1; CMD_0 = 8'hFF;
    plan = '{K_NOACK, K_NOACK, K_NOACK};
    do_txn(0, 1'b0, 1'b1);
    REQ_1 = 1'b1; CMD_1 = 8'hEB;
    plan = '{K_NOSENT, K_NOSENT, K_NOSENT};
    do_txn(0, 1'b0, 1'b0);

    // Idle receiver data is ignored; an unexpected byte fails immediately.
    idle_rx_noise();
    REQ_0 = 1'b1; CMD_0 = 8'hF2;
    plan = '{K_OTHER, K_ACK, K_ACK};
    do_txn(0, 1'b0, 1'b0);

    // Randomised traffic.
    for (int t = 0; t < 30; t++) begin
      if (!REQ_0 && !REQ_1) begin
        if ($urandom_range(0, 4) == 0) idle_rx_noise();
        r0 = 1'($urandom); r1 = 1'($urandom);
        if (!r0 && !r1) r0 = 1'b1;
        if (r0) begin REQ_0 = 1'b1; CMD_0 = 8'($urandom); end
        if (r1) begin REQ_1 = 1'b1; CMD_1 = 8'($urandom); end
      end
      random_plan();
      drop = ($urandom_range(0, 5) == 0);
      do_txn(0, ($urandom_range(0, 5) == 0), drop);
    end
    REQ_0 = 1'b0; REQ_1 = 1'b0;
    repeat (2) tick();

    // Reset while waiting for the acknowledge.
    REQ_1 = 1'b1; CMD_1 = 8'hF6;
    tick();
    check("rst_case_send", SEND_BYTE, 1);
    repeat (2) tick();
    BYTE_SENT = 1'b1; tick(); BYTE_SENT = 1'b0;
    repeat (3) tick();
    d0 = n_done0; d1 = n_done1;
    RESET = 1'b1; REQ_1 = 1'b0;
    tick();
    check("midrst_busy", BUSY, 0);
    check("midrst_send", SEND_BYTE, 0);
    check("midrst_done", {DONE_1, DONE_0}, 0);
    check("midrst_byte", BYTE_TO_SEND, 8'h00);
    RESET = 1'b0; model_last = 1'b1;
    repeat (5) tick();
    check("midrst_no_done", (n_done0 - d0) + (n_done1 - d1), 0);

    // After reset requester 0 wins the tie again.
    REQ_0 = 1'b1; CMD_0 = 8'hF5; REQ_1 = 1'b1; CMD_1 = 8'hF4;
    plan = '{K_ACK, K_ACK, K_ACK};
    do_txn(0, 1'b0, 1'b0);
    do_txn(0, 1'b0, 1'b0);

    check("fail_without_done", n_orphan, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
